// File: rtl/posit_mul_pkg.sv
// ----------------------------------------------------------------------------
// posit_mul_pkg: shared defaults and resolver state type for the posit multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package posit_mul_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } res_state_t;

endpackage

`default_nettype wire

// File: rtl/cs_chunk_adder.sv
// ----------------------------------------------------------------------------
// cs_chunk_adder: combinational CHUNK-bit adder with carry in and carry out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cs_chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/cs_resolver.sv
// ----------------------------------------------------------------------------
// cs_resolver: resolves a carry-save (sum, carry) pair, one CHUNK slice per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cs_resolver
    import posit_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    res_state_t       state;
    res_state_t       state_next;
    logic [CW-1:0]    cnt;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] cvec_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             zero_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] r_chunk;
    logic             c_chunk;
    logic [WIDTH-1:0] work_next;
    logic             last_chunk;

    assign last_chunk = (int'(cnt) == NCHUNK - 1);

    // Select the operand slice addressed by the chunk counter
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (int'(cnt) == k) begin
                a_chunk = sum_reg[k*CHUNK +: CHUNK];
                b_chunk = cvec_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    cs_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .sum  (r_chunk),
        .cout (c_chunk)
    );

    always_comb begin
        work_next = work_reg;
        for (int k = 0; k < NCHUNK; k++) begin
            if (int'(cnt) == k) begin
                work_next[k*CHUNK +: CHUNK] = r_chunk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)   state_next = ST_RUN;
            ST_RUN:  if (last_chunk) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Partial sums build up in work_reg so the visible result only changes on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            carry_reg  <= 1'b0;
            sum_reg    <= '0;
            cvec_reg   <= '0;
            work_reg   <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sum_reg   <= in_sum;
                        cvec_reg  <= in_carry;
                        cnt       <= '0;
                        carry_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= c_chunk;
                    cnt       <= cnt + CW'(1);
                    if (last_chunk) begin
                        result_reg <= work_next;
                        cout_reg   <= c_chunk;
                        zero_reg   <= (work_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign out_result = result_reg;
    assign out_cout   = cout_reg;
    assign out_zero   = zero_reg;

endmodule

`default_nettype wire
